// File: rtl/counter_pkg.sv
// Shared types and constants for the counter datapath family.
// Legacy start values let a wrapper map old Mode encodings onto Start (down, continuous).
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam int LEGACY_START_9 = 9;
    localparam int LEGACY_START_5 = 5;
    localparam int LEGACY_START_1 = 1;

endpackage

// File: rtl/mod_next_count.sv
// Combinational next-count for one enabled step: reload, terminal handling, increment/decrement.
// Zero latency, no flow control; the caller decides when the result is registered.
module mod_next_count
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] start_i,
    input  logic             dir_i,
    input  logic             continuous_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic [WIDTH-1:0] reload_o,
    output logic [WIDTH-1:0] terminal_o,
    output logic             at_terminal_o
);

    logic out_of_range;

    assign terminal_o    = (dir_i == DIR_UP) ? start_i : '0;
    assign reload_o      = (dir_i == DIR_UP) ? '0 : start_i;
    assign out_of_range  = (count_i > start_i);
    assign at_terminal_o = !out_of_range && (count_i == terminal_o);

    // Out-of-range recovery also covers Start/Dir changes made mid-run.
    always_comb begin
        next_count_o = count_i;
        if (out_of_range) begin
            next_count_o = reload_o;
        end else if (at_terminal_o) begin
            next_count_o = continuous_i ? reload_o : count_i;
        end else if (dir_i == DIR_UP) begin
            next_count_o = count_i + WIDTH'(1);
        end else begin
            next_count_o = count_i - WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_mod_counter.sv
// Programmable modulo up/down counter with one-shot/continuous modes, Tc pulse and Done/Busy flags.
// Outputs update on the falling edge that samples Load/Enable; no backpressure, Load overrides Enable.
module prog_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Enable,
    input  logic             Load,
    input  logic             Dir,
    input  logic             Continuous,
    input  logic [WIDTH-1:0] Start,
    output logic [WIDTH-1:0] Count,
    output logic             Tc,
    output logic             Done,
    output logic             Busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] step_count;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] terminal;
    logic             at_terminal;
    logic             arrive;

    mod_next_count #(
        .WIDTH (WIDTH)
    ) u_next (
        .count_i       (count_q),
        .start_i       (Start),
        .dir_i         (Dir),
        .continuous_i  (Continuous),
        .next_count_o  (step_count),
        .reload_o      (reload),
        .terminal_o    (terminal),
        .at_terminal_o (at_terminal)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        arrive  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Load) begin
                    count_d = reload;
                    state_d = ST_RUN;
                    arrive  = 1'b1;
                end
            end
            ST_RUN: begin
                if (Load) begin
                    count_d = reload;
                    arrive  = 1'b1;
                end else if (Enable) begin
                    count_d = step_count;
                    arrive  = 1'b1;
                    if (at_terminal && !Continuous) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Only a step or load may pulse Tc; idling at the terminal stays quiet.
        tc_d   = arrive && (state_d == ST_RUN) && (count_d == terminal);
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Count = count_q;
    assign Tc    = tc_q;
    assign Done  = done_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed test-plan steps plus randomized traffic, checked against a behavioural model.
module tb_prog_mod_counter;

    localparam int WIDTH = 4;

    logic             Clk;
    logic             nReset;
    logic             Enable;
    logic             Load;
    logic             Dir;
    logic             Continuous;
    logic [WIDTH-1:0] Start;
    logic [WIDTH-1:0] Count;
    logic             Tc;
    logic             Done;
    logic             Busy;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = idle, 1 = run, 2 = done
    int m_cnt;
    int m_phase;
    int m_tc;

    prog_mod_counter #(.WIDTH(WIDTH)) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Enable     (Enable),
        .Load       (Load),
        .Dir        (Dir),
        .Continuous (Continuous),
        .Start      (Start),
        .Count      (Count),
        .Tc         (Tc),
        .Done       (Done),
        .Busy       (Busy)
    );

    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_phase = 0;
        m_tc    = 0;
    endtask

    task automatic model_step();
        int term, rel, ncnt, nph, arr;
        term = Dir ? int'(Start) : 0;
        rel  = Dir ? 0 : int'(Start);
        ncnt = m_cnt;
        nph  = m_phase;
        arr  = 0;
        if (Load) begin
            ncnt = rel; nph = 1; arr = 1;
        end else if (m_phase == 1 && Enable) begin
            arr = 1;
            if (m_cnt > int'(Start))      ncnt = rel;
            else if (m_cnt == term) begin
                if (Continuous)           ncnt = rel;
                else                      nph  = 2;
            end else if (Dir)             ncnt = m_cnt + 1;
            else                          ncnt = m_cnt - 1;
        end
        m_tc    = (arr == 1 && nph == 1 && ncnt == term) ? 1 : 0;
        m_cnt   = ncnt;
        m_phase = nph;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, 32'(Count), 32'(m_cnt));
        check({tag, ".tc"},    32'(Tc),    32'(m_tc));
        check({tag, ".done"},  32'(Done),  32'(m_phase == 2));
        check({tag, ".busy"},  32'(Busy),  32'(m_phase == 1));
    endtask

    task automatic tick(input logic ld, input logic en, input string tag);
        Load   = ld;
        Enable = en;
        @(negedge Clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic set_cfg(input int s, input logic d, input logic c);
        Start      = WIDTH'(s);
        Dir        = d;
        Continuous = c;
    endtask

    initial begin
        int exp_cnt;
        nReset = 1'b0; Enable = 1'b0; Load = 1'b0;
        set_cfg(9, 1'b0, 1'b1);
        model_reset();
        #2;
        check("reset.count", 32'(Count), 0);
        check("reset.tc",    32'(Tc),    0);
        check("reset.done",  32'(Done),  0);
        check("reset.busy",  32'(Busy),  0);
        @(negedge Clk); #1;
        nReset = 1'b1;

        // Idle ignores Enable
        tick(1'b0, 1'b1, "idle_hold");
        check("idle_hold.count_c", 32'(Count), 0);

        // Continuous down
        tick(1'b1, 1'b0, "cdown_load");
        check("cdown_load.count_c", 32'(Count), 9);
        for (int i = 0; i < 11; i++) begin
            exp_cnt = (18 - i) % 10;
            tick(1'b0, 1'b1, "cdown");
            check("cdown.count_c", 32'(Count), 32'(exp_cnt));
            check("cdown.tc_c",    32'(Tc),    32'(exp_cnt == 0));
            check("cdown.busy_c",  32'(Busy),  1);
        end

        // One-shot down
        set_cfg(5, 1'b0, 1'b0);
        tick(1'b1, 1'b0, "oneshot_load");
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, "oneshot");
        check("oneshot.at0", 32'(Count), 0);
        check("oneshot.tc0", 32'(Tc),    1);
        tick(1'b0, 1'b1, "oneshot_done");
        check("oneshot_done.done_c", 32'(Done), 1);
        check("oneshot_done.busy_c", 32'(Busy), 0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, "oneshot_hold");
            check("oneshot_hold.count_c", 32'(Count), 0);
        end
        tick(1'b1, 1'b1, "oneshot_reload");
        check("oneshot_reload.count_c", 32'(Count), 5);
        check("oneshot_reload.busy_c",  32'(Busy),  1);

        // Continuous up
        set_cfg(3, 1'b1, 1'b1);
        tick(1'b1, 1'b0, "cup_load");
        check("cup_load.count_c", 32'(Count), 0);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b0, 1'b1, "cup");
            check("cup.count_c", 32'(Count), 32'(i % 4));
            check("cup.tc_c",    32'(Tc),    32'((i % 4) == 3));
        end

        // Enable gating
        set_cfg(9, 1'b0, 1'b1);
        tick(1'b1, 1'b0, "gate_load");
        tick(1'b0, 1'b1, "gate");
        tick(1'b0, 1'b1, "gate");
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, "gate_hold");
            check("gate_hold.count_c", 32'(Count), 7);
        end
        tick(1'b1, 1'b0, "gate_reload");
        check("gate_reload.count_c", 32'(Count), 9);

        // Out of range, down then up
        tick(1'b0, 1'b1, "oor_dn_pre");
        Start = WIDTH'(5);
        tick(1'b0, 1'b1, "oor_dn");
        check("oor_dn.count_c", 32'(Count), 5);
        set_cfg(9, 1'b1, 1'b1);
        tick(1'b1, 1'b0, "oor_up_load");
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, "oor_up_pre");
        Start = WIDTH'(3);
        tick(1'b0, 1'b1, "oor_up");
        check("oor_up.count_c", 32'(Count), 0);

        // Start = 0 degenerate
        set_cfg(0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, "zero_load");
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, "zero_cont");
            check("zero_cont.tc_c", 32'(Tc), 1);
        end
        Continuous = 1'b0;
        tick(1'b0, 1'b1, "zero_oneshot");
        check("zero_oneshot.done_c", 32'(Done), 1);

        // Reset mid-count
        set_cfg(9, 1'b0, 1'b1);
        tick(1'b1, 1'b0, "rst_load");
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, "rst_pre");
        check("rst_pre.count_c", 32'(Count), 4);
        @(posedge Clk);
        nReset = 1'b0;
        #1;
        model_reset();
        check("rst_mid.count", 32'(Count), 0);
        check("rst_mid.tc",    32'(Tc),    0);
        check("rst_mid.done",  32'(Done),  0);
        check("rst_mid.busy",  32'(Busy),  0);
        @(negedge Clk); #1;
        nReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, "rst_after");
            check("rst_after.count_c", 32'(Count), 0);
        end
        tick(1'b1, 1'b0, "rst_reload");
        check("rst_reload.count_c", 32'(Count), 9);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) Start      = WIDTH'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) Dir        = ~Dir;
            if ($urandom_range(0, 29) == 0) Continuous = ~Continuous;
            if ($urandom_range(0, 149) == 0) begin
                nReset = 1'b0;
                #2;
                model_reset();
                check("rand_rst.count", 32'(Count), 0);
                check("rand_rst.busy",  32'(Busy),  0);
                nReset = 1'b1;
            end
            tick(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_mod_counter.md
# prog_mod_counter

Parametrised programmable modulo counter: the next-generation replacement for the fixed 9/5/1 down-counters in the counter datapath. The terminal value comes from a run-time `Start` input instead of hard-coded modes, and the block adds up/down direction, one-shot or continuous operation, a terminal-count pulse and a done flag. It sits between the mode/control logic and the display and decoder stages and drives `Count` directly.

## Interface
- `WIDTH`, default 4: counter and `Start` width in bits.
- `Clk`  in  1: clock. All registers update on the **falling** edge, as in the existing counter family.
- `nReset`  in  1: asynchronous, active-low reset.
- `Enable`  in  1: advance one step per falling edge while high in RUN.
- `Load`  in  1: synchronous (re)start command. Has priority over `Enable`.
- `Dir`  in  1: 0 = count down from `Start` to 0; 1 = count up from 0 to `Start`.
- `Continuous`  in  1: 1 = auto-reload at terminal; 0 = one-shot, stop in DONE.
- `Start`  in  WIDTH: modulus/terminal value. Sampled live; it is not latched.
- `Count`  out  WIDTH: current count. Registered.
- `Tc`  out  1: registered pulse, high for the one cycle after `Count` arrives at the terminal value.
- `Done`  out  1: registered. High in DONE.
- `Busy`  out  1: registered. High in RUN.

## Operation
- Terminal value `T`: 0 when `Dir=0`; `Start` when `Dir=1`.
- Reload value `R`: `Start` when `Dir=0`; 0 when `Dir=1`.
- States: IDLE, RUN, DONE.
- **IDLE** (after reset): `Count` holds and `Enable` is ignored. `Load` sets `Count<=R` and moves to RUN.
- **RUN**, priority order:
  - `Load`: `Count<=R`, stay in RUN.
  - Else if `Enable`:
    - If `Count` is out of range (`Count>Start`): `Count<=R`. Applies in both directions.
    - Else if `Count==T` and `Continuous=1`: `Count<=R`, stay in RUN.
    - Else if `Count==T` and `Continuous=0`: `Count` holds, go to DONE.
    - Else: `Count<=Count-1` (down) or `Count+1` (up).
  - Else: hold.
- **DONE**: `Count` holds at `T` and `Enable` is ignored. `Load` sets `Count<=R` and moves to RUN.
- `Tc`:
  - Set on any edge where the next `Count` equals the next `T` and the next state is RUN. Any step or load counts as an arrival.
  - Clear on the following edge unless a new arrival occurs.
  - Holding at `T` with `Enable` low does not re-pulse.
- Changes to `Dir` or `Start` during RUN take effect at the next enabled step. They never corrupt state because the out-of-range rule recovers.
- Arithmetic is modulo 2^WIDTH. Wrap-around happens only through the reload rules, never through overflow, since `Count` stays in [0, `Start`] after one step.
- Degenerate case `Start=0`: `Count` stays at 0. In continuous mode `Tc` pulses every enabled edge. In one-shot mode the first enabled step in RUN enters DONE.

## Timing
- Reset (asynchronous, immediate): `Count=0`, `Tc=0`, `Done=0`, `Busy=0`, state IDLE.
- `Count` latency: updates on the falling edge at which `Load`/`Enable` are sampled high. Inputs must be stable around the falling edge.
- `Tc`, `Done` and `Busy` update on the same edge as `Count`. There are no combinational paths from inputs to outputs.
- Simultaneous `Load` and `Enable`: `Load` wins.
- Simultaneous `Load` and terminal in one-shot: `Load` wins and the state stays in RUN.
- `nReset` asserted mid-count: outputs clear immediately. The count does not resume after release; it waits in IDLE for `Load`.

## Structure
- Shared package `counter_pkg`:
  - State enum: IDLE, RUN, DONE.
  - Direction constants: `DIR_DOWN=0`, `DIR_UP=1`.
  - Legacy mode constants (9, 5, 1) so a wrapper can map the old `Mode` encodings onto `Start` with `Dir=DIR_DOWN` and `Continuous=1`.
- One natural sub-module, `mod_next_count`: purely combinational. It computes next `Count` and `at_terminal` from `Count`, `Start`, `Dir` and `Continuous`. The FSM and registers stay in the top level.

## Test plan
- **Continuous down**: reset, `Start=9`, `Dir=0`, `Continuous=1`, pulse `Load`, hold `Enable=1`.
  - Required: `Count` = 9,8,…,0,9,8.
  - `Tc` high only in the cycle `Count=0`.
  - `Busy=1`.
- **One-shot down**: `Start=5`, `Continuous=0`, run to 0.
  - Required: one enabled edge later `Done=1`, `Busy=0`, `Count` held at 0 for 10 further enabled cycles.
  - A subsequent `Load` gives `Count=5`, `Busy=1`.
- **Continuous up**: `Start=3`, `Dir=1`, `Continuous=1`.
  - Required: `Count` = 0,1,2,3,0,1.
  - `Tc` high in each cycle `Count=3`.
- **Enable gating**: count 9,8,7, then drop `Enable` for 4 cycles.
  - Required: `Count` holds 7.
  - A `Load` with `Enable=0` gives `Count=9`.
- **Out of range**: while `Count=8` (down), change `Start` to 5.
  - Required: next enabled edge gives `Count=5`.
  - Same with `Dir=1`, `Start=3`, `Count=8`: next enabled edge gives `Count=0`.
- **Reset mid-count**: assert `nReset` between edges while `Count=4`.
  - Required: `Count=0`, `Tc=0`, `Done=0`, `Busy=0` immediately, without waiting for a clock edge.
  - After release, `Count` stays 0 until `Load`.
